// File: rtl/vfifo_mc_sc.sv
`timescale 1ns/1ps
// Multi-channel single-clock FIFO: NCH independent queues share one dual-port RAM,
// each channel owning the fixed region {channel, pointer}.
module vfifo_mc_sc #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CH_WIDTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CH_WIDTH-1:0]        wr_ch,
    input  logic [DATA_WIDTH-1:0]      wr_d,
    output logic                       wr_err,
    input  logic                       rd_en,
    input  logic [CH_WIDTH-1:0]        rd_ch,
    output logic [DATA_WIDTH-1:0]      rd_q,
    output logic                       rd_valid,
    output logic                       rd_err,
    input  logic                       clr_en,
    input  logic [CH_WIDTH-1:0]        clr_ch,
    output logic [(1<<CH_WIDTH)-1:0]   full,
    output logic [(1<<CH_WIDTH)-1:0]   empty,
    input  logic [CH_WIDTH-1:0]        stat_ch,
    output logic [ADDR_WIDTH:0]        stat_cnt
);

    localparam int NCH   = 1 << CH_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int MEM_D = 1 << (CH_WIDTH + ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [MEM_D];

    logic [CNT_W-1:0]      r_cnt    [NCH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr [NCH];
    logic [ADDR_WIDTH-1:0] r_rd_ptr [NCH];
    logic [NCH-1:0]        r_full;
    logic [NCH-1:0]        r_empty;
    logic                  r_wr_err;
    logic                  r_rd_err;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [CNT_W-1:0]      r_stat_cnt;

    logic [CNT_W-1:0]      w_cnt_nxt [NCH];
    logic [ADDR_WIDTH-1:0] w_wp_nxt  [NCH];
    logic [ADDR_WIDTH-1:0] w_rp_nxt  [NCH];
    logic [NCH-1:0]        w_clr_hit;
    logic [NCH-1:0]        w_wr_hit;
    logic [NCH-1:0]        w_rd_hit;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Acceptance looks only at registered flags, so it never depends on same-cycle traffic.
    assign w_clr_hit = clr_en ? (NCH'(1) << clr_ch) : '0;
    assign w_wr_acc  = wr_en & ~r_full[wr_ch]  & ~w_clr_hit[wr_ch];
    assign w_rd_acc  = rd_en & ~r_empty[rd_ch] & ~w_clr_hit[rd_ch];
    assign w_wr_hit  = w_wr_acc ? (NCH'(1) << wr_ch) : '0;
    assign w_rd_hit  = w_rd_acc ? (NCH'(1) << rd_ch) : '0;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_cnt_nxt[c] = r_cnt[c];
            w_wp_nxt[c]  = r_wr_ptr[c];
            w_rp_nxt[c]  = r_rd_ptr[c];
            if (w_clr_hit[c]) begin
                w_cnt_nxt[c] = '0;
                w_wp_nxt[c]  = '0;
                w_rp_nxt[c]  = '0;
            end else begin
                if (w_wr_hit[c]) w_wp_nxt[c] = r_wr_ptr[c] + 1'b1;
                if (w_rd_hit[c]) w_rp_nxt[c] = r_rd_ptr[c] + 1'b1;
                case ({w_wr_hit[c], w_rd_hit[c]})
                    2'b10:   w_cnt_nxt[c] = r_cnt[c] + 1'b1;
                    2'b01:   w_cnt_nxt[c] = r_cnt[c] - 1'b1;
                    default: w_cnt_nxt[c] = r_cnt[c];
                endcase
            end
        end
    end

    // RAM carries data only; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) r_mem[{wr_ch, r_wr_ptr[wr_ch]}] <= wr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c]    <= '0;
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
            r_full     <= '0;
            r_empty    <= '1;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_q     <= '0;
            r_stat_cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c]    <= w_cnt_nxt[c];
                r_wr_ptr[c] <= w_wp_nxt[c];
                r_rd_ptr[c] <= w_rp_nxt[c];
                r_full[c]   <= (w_cnt_nxt[c] == CNT_W'(DEPTH));
                r_empty[c]  <= (w_cnt_nxt[c] == '0);
            end
            r_wr_err   <= wr_en & r_full[wr_ch]  & ~w_clr_hit[wr_ch];
            r_rd_err   <= rd_en & r_empty[rd_ch] & ~w_clr_hit[rd_ch];
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_q <= r_mem[{rd_ch, r_rd_ptr[rd_ch]}];
            r_stat_cnt <= r_cnt[stat_ch];
        end
    end

    assign wr_err   = r_wr_err;
    assign rd_err   = r_rd_err;
    assign rd_valid = r_rd_valid;
    assign rd_q     = r_rd_q;
    assign full     = r_full;
    assign empty    = r_empty;
    assign stat_cnt = r_stat_cnt;

endmodule

// File: tb/tb_vfifo_mc_sc.sv
`timescale 1ns/1ps
// Directed bench for vfifo_mc_sc: reset, fill/overflow, underflow, interleaved wrap,
// flush priority and full-with-read, all against hand-computed expectations.
module tb_vfifo_mc_sc;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_d;
    logic       wr_err;
    logic       rd_en;
    logic [1:0] rd_ch;
    logic [7:0] rd_q;
    logic       rd_valid;
    logic       rd_err;
    logic       clr_en;
    logic [1:0] clr_ch;
    logic [3:0] full;
    logic [3:0] empty;
    logic [1:0] stat_ch;
    logic [4:0] stat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vfifo_mc_sc #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CH_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_d(wr_d), .wr_err(wr_err),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_q(rd_q), .rd_valid(rd_valid), .rd_err(rd_err),
        .clr_en(clr_en), .clr_ch(clr_ch),
        .full(full), .empty(empty),
        .stat_ch(stat_ch), .stat_cnt(stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; clr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; idle(); wr_ch = 2'd0; wr_d = 8'h00; rd_ch = 2'd0; clr_ch = 2'd0; stat_ch = 2'd1;
        #2;

        // Reset with requests active
        rst = 1'b1; wr_en = 1'b1; wr_d = 8'hE1; rd_en = 1'b1;
        step(); step();
        rst = 1'b0; idle();
        check("rst_empty",    32'(empty), 32'hF);
        check("rst_full",     32'(full), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_err",   32'(rd_err), 0);
        check("rst_wr_err",   32'(wr_err), 0);
        check("rst_rd_q",     32'(rd_q), 0);
        check("rst_stat_cnt", 32'(stat_cnt), 0);
        step();
        check("rst_no_data",  32'(empty), 32'hF);

        // Fill ch1 and overflow
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_ch = 2'd1; wr_d = 8'(i);
            step();
        end
        check("fill_full", 32'(full), 32'h2);
        check("fill_no_err", 32'(wr_err), 0);
        wr_d = 8'hAA;
        step();
        idle();
        check("ovf_wr_err", 32'(wr_err), 1);
        check("ovf_full",   32'(full), 32'h2);
        step();
        check("ovf_err_pulse", 32'(wr_err), 0);
        check("fill_stat16",   32'(stat_cnt), 16);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_ch = 2'd1;
            step();
            check("drain1_valid", 32'(rd_valid), 1);
            check("drain1_data",  32'(rd_q), 32'(i));
        end
        idle();
        step();
        check("drain1_vld_lo", 32'(rd_valid), 0);
        check("drain1_hold",   32'(rd_q), 32'h0F);
        check("drain1_empty",  32'(empty), 32'hF);

        // Underflow with same-cycle write on empty ch2
        wr_en = 1'b1; wr_ch = 2'd2; wr_d = 8'h5C; rd_en = 1'b1; rd_ch = 2'd2;
        step();
        check("udf_rd_err",   32'(rd_err), 1);
        check("udf_rd_valid", 32'(rd_valid), 0);
        check("udf_wr_err",   32'(wr_err), 0);
        wr_en = 1'b0;
        step();
        check("udf_next_valid", 32'(rd_valid), 1);
        check("udf_next_data",  32'(rd_q), 32'h5C);
        check("udf_next_err",   32'(rd_err), 0);
        idle();
        step();
        check("udf_empty", 32'(empty), 32'hF);

        // Interleaved ch0/ch3 stream, 40 words each, pointers wrap
        stat_ch = 2'd0;
        for (int k = 0; k <= 80; k++) begin
            wr_en = (k < 80);
            wr_ch = (k % 2 == 1) ? 2'd3 : 2'd0;
            wr_d  = (k % 2 == 1) ? 8'(8'h80 + k / 2) : 8'(k / 2);
            rd_en = (k > 0);
            rd_ch = ((k - 1) % 2 == 1) ? 2'd3 : 2'd0;
            step();
            if (k > 0) begin
                check("ilv_valid", 32'(rd_valid), 1);
                check("ilv_data",  32'(rd_q),
                      ((k - 1) % 2 == 1) ? 32'(8'h80 + (k - 1) / 2) : 32'((k - 1) / 2));
                check("ilv_cnt_le1", 32'(stat_cnt > 5'd1), 0);
            end
        end
        idle();
        step();
        check("ilv_empty", 32'(empty), 32'hF);
        check("ilv_full",  32'(full), 32'h0);

        // Flush priority on ch0 holding 5 words; ch2 holds 2
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_ch = 2'd0; wr_d = 8'(8'h10 + i);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_ch = 2'd2; wr_d = 8'(8'h40 + i);
            step();
        end
        clr_en = 1'b1; clr_ch = 2'd0;
        wr_en = 1'b1; wr_ch = 2'd0; wr_d = 8'h99; rd_en = 1'b1; rd_ch = 2'd0;
        step();
        idle();
        check("clr_wr_err",   32'(wr_err), 0);
        check("clr_rd_err",   32'(rd_err), 0);
        check("clr_rd_valid", 32'(rd_valid), 0);
        check("clr_empty",    32'(empty), 32'hB);
        stat_ch = 2'd0;
        step(); step();
        check("clr_stat0", 32'(stat_cnt), 0);
        stat_ch = 2'd2;
        step(); step();
        check("clr_stat2", 32'(stat_cnt), 2);
        rd_en = 1'b1; rd_ch = 2'd0;
        step();
        check("clr_rd_after", 32'(rd_err), 1);
        rd_ch = 2'd2;
        step();
        check("clr_ch2_d0", 32'(rd_q), 32'h40);
        step();
        check("clr_ch2_d1", 32'(rd_q), 32'h41);
        idle();
        step();
        check("clr_all_empty", 32'(empty), 32'hF);

        // Full ch1 plus simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_ch = 2'd1; wr_d = 8'(8'h20 + i);
            step();
        end
        wr_d = 8'h77; rd_en = 1'b1; rd_ch = 2'd1;
        step();
        idle();
        check("frd_valid",  32'(rd_valid), 1);
        check("frd_data",   32'(rd_q), 32'h20);
        check("frd_wr_err", 32'(wr_err), 1);
        check("frd_full",   32'(full), 32'h0);
        stat_ch = 2'd1;
        step(); step();
        check("frd_stat15", 32'(stat_cnt), 15);
        for (int i = 1; i < 16; i++) begin
            rd_en = 1'b1; rd_ch = 2'd1;
            step();
            check("frd_drain", 32'(rd_q), 32'(8'h20 + i));
        end
        step();
        check("frd_tail_err", 32'(rd_err), 1);
        check("frd_tail_vld", 32'(rd_valid), 0);
        idle();

        // Reset mid-stream discards queued data
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_ch = 2'd3; wr_d = 8'(i);
            step();
        end
        check("mid_not_empty", 32'(empty), 32'h7);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_empty", 32'(empty), 32'hF);
        rd_en = 1'b1; rd_ch = 2'd3;
        step();
        idle();
        check("mid_rst_rd_err", 32'(rd_err), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
